// File: rtl/addsub_operand_seq.sv
// ============================================================================
// Module   : addsub_operand_seq
// Purpose  : Push-button operand sequencer that drives a 4-bit adder/subtractor
//            and latches its result with carry/borrow and overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_data,
  input  logic       sw_mode,
  input  logic       btn,
  input  logic [3:0] s_in,
  input  logic       cout_in,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       m_out,
  output logic [3:0] result,
  output logic       flag,
  output logic       ovf,
  output logic       result_valid,
  output logic [1:0] state_led
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  logic          btn_meta_q, btn_sync_q;
  logic          db_level_q, db_level_d;
  logic [CW-1:0] db_cnt_q,   db_cnt_d;
  logic          press_q,    press_d;

  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic          m_q, m_d, flag_q, flag_d, ovf_q, ovf_d, valid_q, valid_d;
  logic          w_ovf;

  // Debounce: the synchronised level must disagree for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == CNT_MAX) begin
        db_level_d = ~db_level_q;
        press_d    = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  assign w_ovf = m_q ? ((a_q[3] != b_q[3]) && (s_in[3] != a_q[3]))
                     : ((a_q[3] == b_q[3]) && (s_in[3] != a_q[3]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    res_d   = res_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      LOAD_A: if (press_q) begin
        a_d     = sw_data;
        state_d = LOAD_B;
      end
      LOAD_B: if (press_q) begin
        b_d     = sw_data;
        m_d     = sw_mode;
        state_d = CALC;
      end
      // Operands were registered last cycle, so s_in/cout_in have settled here.
      CALC: begin
        res_d   = s_in;
        flag_d  = cout_in ^ m_q;
        ovf_d   = w_ovf;
        valid_d = 1'b1;
        state_d = SHOW;
      end
      SHOW: if (press_q) begin
        res_d   = '0;
        flag_d  = 1'b0;
        ovf_d   = 1'b0;
        valid_d = 1'b0;
        state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= 1'b0;
      res_q      <= '0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_q        <= m_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign m_out        = m_q;
  assign result       = res_q;
  assign flag         = flag_q;
  assign ovf          = ovf_q;
  assign result_valid = valid_q;
  assign state_led    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_operand_seq.sv
// ============================================================================
// Module   : tb_addsub_operand_seq
// Purpose  : Self-checking bench for addsub_operand_seq with an addsub model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_operand_seq;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_data;
  logic       sw_mode;
  logic       btn;
  logic [3:0] s_in;
  logic       cout_in;
  logic [3:0] a_out, b_out, result;
  logic       m_out, flag, ovf, result_valid;
  logic [1:0] state_led;
  logic [4:0] sum5;

  int errors = 0;
  int checks = 0;

  addsub_operand_seq #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .sw_data(sw_data), .sw_mode(sw_mode), .btn(btn),
    .s_in(s_in), .cout_in(cout_in), .a_out(a_out), .b_out(b_out), .m_out(m_out),
    .result(result), .flag(flag), .ovf(ovf), .result_valid(result_valid),
    .state_led(state_led)
  );

  always #5 clk = ~clk;

  // Combinational adder/subtractor on the board: S = A + (B ^ M) + M.
  always_comb begin
    sum5    = {1'b0, a_out} + {1'b0, b_out ^ {4{m_out}}} + {4'b0, m_out};
    s_in    = sum5[3:0];
    cout_in = sum5[4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic view of the expected outcome, independent of the gate-level identity.
  function automatic void ref_op(input int a, input int b, input int m,
                                 output int r, output int f, output int o);
    int sa, sb, full;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (m != 0) begin
      full = sa - sb;
      r    = (a - b) & 15;
      f    = (a < b) ? 1 : 0;
    end else begin
      full = sa + sb;
      r    = (a + b) & 15;
      f    = (a + b > 15) ? 1 : 0;
    end
    o = (full > 7 || full < -8) ? 1 : 0;
  endfunction

  task automatic press(output int calc_cycles);
    calc_cycles = 0;
    btn = 1'b1;
    repeat (DC + 6) begin
      tick();
      if (state_led == 2'b10) calc_cycles++;
    end
    btn = 1'b0;
    repeat (DC + 6) begin
      tick();
      if (state_led == 2'b10) calc_cycles++;
    end
    sw_data = 4'($urandom);
    sw_mode = 1'($urandom);
  endtask

  task automatic run_op(input int a, input int b, input int m, input bit do_exit);
    int r, f, o, cc;
    ref_op(a, b, m, r, f, o);
    sw_data = 4'(a);
    press(cc);
    check("load_a", a_out, a);
    check("state_b", state_led, 1);
    sw_data = 4'(b);
    sw_mode = 1'(m);
    press(cc);
    check("calc_len", cc, 1);
    check("result", result, r);
    check("flag", flag, f);
    check("ovf", ovf, o);
    check("valid", result_valid, 1);
    check("state_show", state_led, 3);
    check("m_out", m_out, m);
    if (do_exit) begin
      press(cc);
      check("exit_result", result, 0);
      check("exit_flag", flag, 0);
      check("exit_ovf", ovf, 0);
      check("exit_valid", result_valid, 0);
      check("exit_state", state_led, 0);
      check("exit_a", a_out, a);
      check("exit_b", b_out, b);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, a_out, 0);
    check({tag, "_b"}, b_out, 0);
    check({tag, "_m"}, m_out, 0);
    check({tag, "_res"}, result, 0);
    check({tag, "_flag"}, flag, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_state"}, state_led, 0);
  endtask

  initial begin
    int cc, lat;
    bit seen;
    reset = 1'b1; btn = 1'b0; sw_data = 4'd0; sw_mode = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all_zero("rst");

    run_op(3, 4, 0, 1'b1);
    run_op(12, 7, 1, 1'b1);
    run_op(3, 5, 1, 1'b1);
    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)), 1'b1);

    // Bouncing press followed by a stable hold.
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      repeat (2) tick();
    end
    check("bounce_no_adv", state_led, 0);
    btn = 1'b1;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (!seen && state_led == 2'b01) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("press_seen", seen, 1);
    check("press_latency", lat, DC + 3);
    check("held_once", state_led, 1);
    btn = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      repeat (2) tick();
    end
    btn = 1'b0;
    repeat (20) tick();
    check("release_no_adv", state_led, 1);

    // Reset in LOAD_B discards the partial operand.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    sw_data = 4'd9;
    press(cc);
    check("mid_load_a", a_out, 9);
    check("mid_state", state_led, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_all_zero("mid_rst");
    sw_data = 4'd6;
    press(cc);
    check("post_rst_a", a_out, 6);
    check("post_rst_state", state_led, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
